// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI receive controller.
package qspi_pkg;

  localparam int WORD_W       = 32;
  localparam int NIB_PER_WORD = 8;
  localparam int NIB_CNT_W    = $clog2(NIB_PER_WORD);
  localparam int BYTES_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STALL = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Nibbles in a closed word are always even, so halving gives whole bytes.
  function automatic logic [BYTES_W-1:0] nibs_to_bytes(input logic [NIB_CNT_W:0] nibs);
    return BYTES_W'(nibs >> 1);
  endfunction

endpackage

// File: rtl/qspi_rx_word_reg.sv
// Output holding register for assembled receive words with a valid/ready handshake.
module qspi_rx_word_reg
  import qspi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [WORD_W-1:0]  data,
  input  logic [BYTES_W-1:0] bytes,
  input  logic               last,
  input  logic               ready,
  output logic [WORD_W-1:0]  word,
  output logic               valid,
  output logic [BYTES_W-1:0] word_bytes,
  output logic               word_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      valid      <= 1'b0;
      word_bytes <= '0;
      word_last  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      word       <= data;
      word_bytes <= bytes;
      word_last  <= last;
      valid      <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qspi_rx_ctrl.sv
// QSPI read-transfer sequencer: gates the nibble shift stage and packs nibbles into output words.
//   state    | meaning
//   ST_IDLE  | waiting for start_i
//   ST_SHIFT | one nibble sampled per cycle
//   ST_STALL | closing nibble held back until the output register can take the word
//   ST_DRAIN | all nibbles shifted, waiting for the last word to be accepted
module qspi_rx_ctrl
  import qspi_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               lsb_first_i,
  input  logic               abort_i,
  output logic               sck_en_o,
  output logic               shift_valid_o,
  output logic               shift_lsb_o,
  output logic               shift_msb_o,
  input  logic [WORD_W-1:0]  shift_data_i,
  output logic [WORD_W-1:0]  word_o,
  output logic               word_valid_o,
  input  logic               word_ready_i,
  output logic [BYTES_W-1:0] word_bytes_o,
  output logic               word_last_o,
  output logic               busy_o,
  output logic               done_o
);

  state_t               state;
  logic [NIB_CNT_W-1:0] nib_cnt;
  logic [LEN_W:0]       rem_nib;
  logic                 cap_pend;
  logic [BYTES_W-1:0]   cap_bytes;
  logic                 cap_last;
  logic                 lsb_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 final_nib;
  logic                 closing;
  logic                 shift_ok;
  logic                 shift_en;
  logic                 last_accept;
  logic [NIB_CNT_W:0]   nib_in_word;

  assign final_nib   = (rem_nib == (LEN_W+1)'(1));
  assign closing     = final_nib || (nib_cnt == NIB_CNT_W'(NIB_PER_WORD - 1));
  assign shift_ok    = !closing || (!cap_pend && (!word_valid_o || word_ready_i));
  assign nib_in_word = {1'b0, nib_cnt} + (NIB_CNT_W+1)'(1);
  assign last_accept = (state == ST_DRAIN) && word_valid_o && word_ready_i && word_last_o;

  // Shift enable depends on the same-cycle word_ready_i, so it cannot be a flop.
  assign shift_en      = (state == ST_SHIFT) && shift_ok && !abort_i;
  assign sck_en_o      = shift_en;
  assign shift_valid_o = shift_en;
  assign shift_lsb_o   = lsb_q;
  assign shift_msb_o   = ~lsb_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      nib_cnt   <= '0;
      rem_nib   <= '0;
      cap_pend  <= 1'b0;
      cap_bytes <= '0;
      cap_last  <= 1'b0;
      lsb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      cap_pend <= 1'b0;
      if (abort_i) begin
        state   <= ST_IDLE;
        busy_q  <= 1'b0;
        nib_cnt <= '0;
        rem_nib <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              if (len_i != '0) begin
                state   <= ST_SHIFT;
                busy_q  <= 1'b1;
                rem_nib <= {len_i, 1'b0};
                nib_cnt <= '0;
                lsb_q   <= lsb_first_i;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ST_SHIFT: begin
            if (shift_en) begin
              rem_nib <= rem_nib - (LEN_W+1)'(1);
              nib_cnt <= closing ? '0 : nib_cnt + NIB_CNT_W'(1);
              if (closing) begin
                cap_pend  <= 1'b1;
                cap_bytes <= nibs_to_bytes(nib_in_word);
                cap_last  <= final_nib;
              end
              if (final_nib) state <= ST_DRAIN;
            end else begin
              state <= ST_STALL;
            end
          end
          ST_STALL: begin
            if (shift_ok) state <= ST_SHIFT;
          end
          ST_DRAIN: begin
            if (last_accept) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  qspi_rx_word_reg u_word_reg (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear      (abort_i),
    .load       (cap_pend),
    .data       (shift_data_i),
    .bytes      (cap_bytes),
    .last       (cap_last),
    .ready      (word_ready_i),
    .word       (word_o),
    .valid      (word_valid_o),
    .word_bytes (word_bytes_o),
    .word_last  (word_last_o)
  );

endmodule

// File: tb/tb_qspi_rx_ctrl.sv
// Self-checking bench for qspi_rx_ctrl with a behavioural nibble shift stage and word reference.
module tb_qspi_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  len_i = 8'd0;
  logic        lsb_first_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        sck_en_o, shift_valid_o, shift_lsb_o, shift_msb_o;
  logic [31:0] shift_data_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b1;
  logic [2:0]  word_bytes_o;
  logic        word_last_o;
  logic        busy_o, done_o;

  int checks = 0;
  int failures = 0;

  qspi_rx_ctrl #(.LEN_W(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .len_i         (len_i),
    .lsb_first_i   (lsb_first_i),
    .abort_i       (abort_i),
    .sck_en_o      (sck_en_o),
    .shift_valid_o (shift_valid_o),
    .shift_lsb_o   (shift_lsb_o),
    .shift_msb_o   (shift_msb_o),
    .shift_data_i  (shift_data_i),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .word_ready_i  (word_ready_i),
    .word_bytes_o  (word_bytes_o),
    .word_last_o   (word_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  // ---------------- observation state (written only by the negedge monitor) ----------------
  int          epoch = 0, obs_epoch = 0, st_epoch = 0;
  int          cyc = 0, sck_n = 0, gaps = 0, last_sck = -1;
  int          done_n = 0, done_cyc = -1, acc_cyc = -1, wv_n = 0, unstable = 0, sv_mism = 0;
  logic [3:0]  hist[$];
  logic [31:0] acc_w[$];
  logic [2:0]  acc_b[$];
  logic        acc_l[$];
  bit          sv_q = 0, lsb_q = 0, hold = 0;
  logic [3:0]  cur_nib = 4'd0;
  logic [31:0] hold_w;
  logic [2:0]  hold_b;
  logic        hold_l;

  bit rdy_rand = 0;
  bit rdy_force0 = 0;

  always @(negedge clk) begin
    if (obs_epoch != epoch) begin
      obs_epoch = epoch;
      sck_n = 0; gaps = 0; last_sck = -1; done_n = 0; done_cyc = -1; acc_cyc = -1;
      wv_n = 0; unstable = 0; sv_mism = 0; hold = 0;
      hist.delete(); acc_w.delete(); acc_b.delete(); acc_l.delete();
    end
    cyc++;
    sv_q  = shift_valid_o;
    lsb_q = shift_lsb_o;
    if (sck_en_o !== shift_valid_o) sv_mism++;
    if (shift_valid_o) begin
      cur_nib = 4'($urandom);
      hist.push_back(cur_nib);
      sck_n++;
      if (last_sck >= 0 && cyc != last_sck + 1) gaps++;
      last_sck = cyc;
    end
    if (word_valid_o) wv_n++;
    if (hold && word_valid_o && (word_o !== hold_w || word_bytes_o !== hold_b || word_last_o !== hold_l))
      unstable++;
    hold   = word_valid_o && !word_ready_i;
    hold_w = word_o; hold_b = word_bytes_o; hold_l = word_last_o;
    if (word_valid_o && word_ready_i) begin
      acc_w.push_back(word_o); acc_b.push_back(word_bytes_o); acc_l.push_back(word_last_o);
      acc_cyc = cyc;
    end
    if (done_o) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  // Behavioural RX nibble shift stage, cleared at the start of every scenario.
  always @(posedge clk) begin
    if (st_epoch != epoch) begin
      st_epoch = epoch;
      shift_data_i <= '0;
    end else if (sv_q) begin
      shift_data_i <= lsb_q ? {cur_nib, shift_data_i[31:4]} : {shift_data_i[27:0], cur_nib};
    end
  end

  always @(posedge clk) begin
    #1;
    word_ready_i = rdy_force0 ? 1'b0 : (rdy_rand ? 1'($urandom) : 1'b1);
  end

  // ---------------- reference model ----------------
  function automatic int exp_bytes(input int len, input int k);
    return (len - 4 * k >= 4) ? 4 : len - 4 * k;
  endfunction

  function automatic int exp_words(input int len);
    return (len + 3) / 4;
  endfunction

  // A word holds the most recent (up to 8) nibbles of the stream, newest at the
  // bottom in MSB-first mode and at the top in LSB-first mode.
  function automatic logic [31:0] exp_word(input int cum, input bit lsb);
    logic [31:0] w = '0;
    for (int j = (cum > 8 ? cum - 8 : 0); j < cum; j++)
      w = lsb ? {hist[j], w[31:4]} : {w[27:0], hist[j]};
    return w;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic new_epoch;
    epoch++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input bit lsb);
    start_i = 1'b1; len_i = 8'(len); lsb_first_i = lsb;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (done_n > 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    tick;
    checks++;
    if ({sck_en_o, shift_valid_o, shift_lsb_o, shift_msb_o} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_shift_ctrl got=%b exp=0001", {sck_en_o, shift_valid_o, shift_lsb_o, shift_msb_o});
    end
    checks++;
    if ({word_valid_o, word_last_o, busy_o, done_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {word_valid_o, word_last_o, busy_o, done_o});
    end
    checks++;
    if (word_o !== 32'h0 || word_bytes_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_word got=%h/%0d exp=0/0", word_o, word_bytes_o);
    end
  endtask

  task automatic test_len4_msb;
    bit ok;
    rdy_rand = 0; rdy_force0 = 0;
    new_epoch;
    do_start(4, 0);
    checks++;
    if (busy_o !== 1'b1 || shift_msb_o !== 1'b1 || shift_lsb_o !== 1'b0) begin
      failures++;
      $display("FAIL len4_mode got busy=%b msb=%b lsb=%b exp busy=1 msb=1 lsb=0", busy_o, shift_msb_o, shift_lsb_o);
    end
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL len4_timeout got done=0 exp done=1"); end
    checks++;
    if (sck_n != 8 || gaps != 0) begin
      failures++;
      $display("FAIL len4_sck got n=%0d gaps=%0d exp n=8 gaps=0", sck_n, gaps);
    end
    checks++;
    if (acc_w.size() != 1) begin
      failures++;
      $display("FAIL len4_words got=%0d exp=1", acc_w.size());
    end else if (acc_w[0] !== exp_word(8, 0) || acc_b[0] !== 3'd4 || acc_l[0] !== 1'b1) begin
      failures++;
      $display("FAIL len4_word got=%h/%0d/%b exp=%h/4/1", acc_w[0], acc_b[0], acc_l[0], exp_word(8, 0));
    end
    checks++;
    if (done_cyc != acc_cyc + 1) begin
      failures++;
      $display("FAIL len4_done_timing got=%0d exp=%0d", done_cyc, acc_cyc + 1);
    end
    tick; tick;
    checks++;
    if (done_n != 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL len4_done_pulse got n=%0d busy=%b exp n=1 busy=0", done_n, busy_o);
    end
  endtask

  task automatic test_len10;
    bit ok;
    int cum;
    rdy_rand = 0; rdy_force0 = 0;
    new_epoch;
    do_start(10, 0);
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL len10_timeout got done=0 exp done=1"); end
    checks++;
    if (sck_n != 20 || gaps != 0) begin
      failures++;
      $display("FAIL len10_sck got n=%0d gaps=%0d exp n=20 gaps=0", sck_n, gaps);
    end
    checks++;
    if (acc_w.size() != 3) begin
      failures++;
      $display("FAIL len10_words got=%0d exp=3", acc_w.size());
    end
    cum = 0;
    for (int k = 0; k < 3 && k < acc_w.size(); k++) begin
      cum += 2 * exp_bytes(10, k);
      checks++;
      if (acc_w[k] !== exp_word(cum, 0) || acc_b[k] !== 3'(exp_bytes(10, k)) || acc_l[k] !== (k == 2)) begin
        failures++;
        $display("FAIL len10_word%0d got=%h/%0d/%b exp=%h/%0d/%b", k, acc_w[k], acc_b[k], acc_l[k],
                 exp_word(cum, 0), exp_bytes(10, k), (k == 2));
      end
    end
  endtask

  task automatic test_lsb_len1;
    bit ok;
    rdy_rand = 0; rdy_force0 = 0;
    new_epoch;
    do_start(1, 1);
    tick;
    checks++;
    if (shift_lsb_o !== 1'b1 || shift_msb_o !== 1'b0) begin
      failures++;
      $display("FAIL lsb1_mode got lsb=%b msb=%b exp lsb=1 msb=0", shift_lsb_o, shift_msb_o);
    end
    wait_done(50, ok);
    checks++;
    if (!ok || sck_n != 2) begin
      failures++;
      $display("FAIL lsb1_sck got done=%b n=%0d exp done=1 n=2", ok, sck_n);
    end
    checks++;
    if (acc_w.size() != 1) begin
      failures++;
      $display("FAIL lsb1_words got=%0d exp=1", acc_w.size());
    end else if (acc_w[0] !== exp_word(2, 1) || acc_b[0] !== 3'd1 || acc_l[0] !== 1'b1) begin
      failures++;
      $display("FAIL lsb1_word got=%h/%0d/%b exp=%h/1/1", acc_w[0], acc_b[0], acc_l[0], exp_word(2, 1));
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int cum;
    rdy_rand = 0; rdy_force0 = 1;
    new_epoch;
    do_start(8, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (word_valid_o) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_first_word got valid=0 exp valid=1"); end
    repeat (12) tick;
    checks++;
    if (sck_n != 15 || sck_en_o !== 1'b0 || word_valid_o !== 1'b1 || acc_w.size() != 0) begin
      failures++;
      $display("FAIL bp_stall got n=%0d sck=%b valid=%b acc=%0d exp n=15 sck=0 valid=1 acc=0",
               sck_n, sck_en_o, word_valid_o, acc_w.size());
    end
    rdy_force0 = 0;
    wait_done(100, ok);
    checks++;
    if (!ok || sck_n != 16 || unstable != 0) begin
      failures++;
      $display("FAIL bp_finish got done=%b n=%0d unstable=%0d exp done=1 n=16 unstable=0", ok, sck_n, unstable);
    end
    checks++;
    if (acc_w.size() != 2) begin
      failures++;
      $display("FAIL bp_words got=%0d exp=2", acc_w.size());
    end
    cum = 0;
    for (int k = 0; k < 2 && k < acc_w.size(); k++) begin
      cum += 8;
      checks++;
      if (acc_w[k] !== exp_word(cum, 0) || acc_b[k] !== 3'd4 || acc_l[k] !== (k == 1)) begin
        failures++;
        $display("FAIL bp_word%0d got=%h/%0d/%b exp=%h/4/%b", k, acc_w[k], acc_b[k], acc_l[k], exp_word(cum, 0), (k == 1));
      end
    end
  endtask

  task automatic test_abort;
    bit ok;
    rdy_rand = 0; rdy_force0 = 0;
    new_epoch;
    do_start(8, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (sck_n >= 2) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 start_i = 1'b1; len_i = 8'd1; lsb_first_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int i = 0; i < 20 && sck_n < 5; i++) tick;
    checks++;
    if (!ok || sck_n != 5) begin
      failures++;
      $display("FAIL abort_reach got n=%0d exp n=5", sck_n);
    end
    @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    tick;
    checks++;
    if (busy_o !== 1'b0 || sck_en_o !== 1'b0 || shift_lsb_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b sck=%b lsb=%b exp busy=0 sck=0 lsb=0", busy_o, sck_en_o, shift_lsb_o);
    end
    repeat (10) tick;
    checks++;
    if (sck_n != 5 || wv_n != 0 || done_n != 0) begin
      failures++;
      $display("FAIL abort_quiet got n=%0d valid=%0d done=%0d exp n=5 valid=0 done=0", sck_n, wv_n, done_n);
    end
  endtask

  task automatic test_len0;
    rdy_rand = 0; rdy_force0 = 0;
    new_epoch;
    do_start(0, 0);
    tick;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL len0_done got done=%b busy=%b exp done=1 busy=0", done_o, busy_o);
    end
    repeat (4) tick;
    checks++;
    if (done_n != 1 || sck_n != 0 || wv_n != 0) begin
      failures++;
      $display("FAIL len0_quiet got done=%0d n=%0d valid=%0d exp 1/0/0", done_n, sck_n, wv_n);
    end
  endtask

  task automatic test_random;
    bit ok;
    int len, cum, nw;
    bit lsb;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 12);
      lsb = 1'($urandom);
      rdy_rand = 1'($urandom); rdy_force0 = 0;
      nw = exp_words(len);
      new_epoch;
      do_start(len, lsb);
      wait_done(400, ok);
      tick; tick;
      checks++;
      if (!ok || sck_n != 2 * len || done_n != 1 || unstable != 0 || sv_mism != 0) begin
        failures++;
        $display("FAIL rand%0d_xfer len=%0d got done=%b n=%0d pulses=%0d unstable=%0d svm=%0d exp 1/%0d/1/0/0",
                 it, len, ok, sck_n, done_n, unstable, sv_mism, 2 * len);
      end
      checks++;
      if (acc_w.size() != nw) begin
        failures++;
        $display("FAIL rand%0d_words got=%0d exp=%0d", it, acc_w.size(), nw);
      end
      cum = 0;
      for (int k = 0; k < nw && k < acc_w.size(); k++) begin
        cum += 2 * exp_bytes(len, k);
        checks++;
        if (acc_w[k] !== exp_word(cum, lsb) || acc_b[k] !== 3'(exp_bytes(len, k)) || acc_l[k] !== (k == nw - 1)) begin
          failures++;
          $display("FAIL rand%0d_word%0d got=%h/%0d/%b exp=%h/%0d/%b", it, k, acc_w[k], acc_b[k], acc_l[k],
                   exp_word(cum, lsb), exp_bytes(len, k), (k == nw - 1));
        end
      end
    end
    rdy_rand = 0;
  endtask

  task automatic test_reset_stall;
    bit ok;
    rdy_rand = 0; rdy_force0 = 1;
    new_epoch;
    do_start(8, 1);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (word_valid_o && sck_n == 15 && !sck_en_o && busy_o) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rststall_reach got n=%0d valid=%b exp n=15 valid=1", sck_n, word_valid_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({sck_en_o, shift_valid_o, shift_lsb_o, shift_msb_o, word_valid_o, word_last_o, busy_o, done_o} !== 8'b0001_0000) begin
      failures++;
      $display("FAIL rststall_flags got=%b exp=00010000",
               {sck_en_o, shift_valid_o, shift_lsb_o, shift_msb_o, word_valid_o, word_last_o, busy_o, done_o});
    end
    checks++;
    if (word_o !== 32'h0 || word_bytes_o !== 3'd0) begin
      failures++;
      $display("FAIL rststall_word got=%h/%0d exp=0/0", word_o, word_bytes_o);
    end
    rdy_force0 = 0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    new_epoch;
    repeat (8) tick;
    checks++;
    if (wv_n != 0 || sck_n != 0 || busy_o !== 1'b0 || done_n != 0) begin
      failures++;
      $display("FAIL rststall_resume got valid=%0d n=%0d busy=%b done=%0d exp 0/0/0/0", wv_n, sck_n, busy_o, done_n);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_len4_msb;
    test_len10;
    test_lsb_len1;
    test_backpressure;
    test_abort;
    test_len0;
    test_random;
    test_reset_stall;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_rx_ctrl.md
QSPI_RX_CTRL -- requirements
Module: qspi_rx_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, 8, width of the transfer byte-count input.
REQ-002 SHALL have ports clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous and active-low; one clock, no other clock domains.
REQ-003 SHALL have port start_i  in  1  one-cycle request to start a read transfer.
REQ-004 SHALL have port len_i  in  LEN_W  transfer length in bytes, sampled with start_i.
REQ-005 SHALL have port lsb_first_i  in  1  nibble order, sampled with start_i (1 = LSB first).
REQ-006 SHALL have port abort_i  in  1  terminates any transfer.
REQ-007 SHALL have port sck_en_o  out  1  QSPI clock gate; 1 = one nibble sampled this cycle.
REQ-008 SHALL have ports shift_valid_o, shift_lsb_o, shift_msb_o  out  1 each  drive valid/lsb/msb of the downstream-facing RX nibble shift stage.
REQ-009 SHALL have port shift_data_i  in  32  assembled word from the RX shift stage.
REQ-010 SHALL have ports word_o  out  32, word_valid_o  out  1, word_ready_i  in  1  word output handshake.
REQ-011 SHALL have ports word_bytes_o  out  3  valid bytes in word_o (1..4); word_last_o  out  1  final word of transfer.
REQ-012 SHALL have ports busy_o  out  1 and done_o  out  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE, SHIFT, STALL, DRAIN.
REQ-014 IDLE: start_i with len_i != 0 -> SHIFT next cycle, latching len_i and lsb_first_i; start_i with len_i == 0 -> done_o pulse next cycle, stay IDLE.
REQ-015 start_i while busy_o = 1 SHALL be ignored.
REQ-016 In SHIFT, sck_en_o = shift_valid_o = 1 each cycle; the nibble counter (0..7) and remaining-nibble counter (2*len) update on each such cycle.
REQ-017 shift_lsb_o SHALL equal latched lsb_first_i and shift_msb_o its inverse, held for the whole transfer.
REQ-018 A word closes on the 8th nibble or the final nibble of the transfer; capture_pending SHALL set that edge and, on the next cycle, shift_data_i SHALL be copied unchanged into word_o with word_valid_o = 1.
REQ-019 word_bytes_o = nibbles in closed word / 2; word_last_o = 1 only for the word closed by the final nibble.
REQ-020 Shifting SHALL continue across word boundaries with zero bubbles while the output register is free.
REQ-021 The closing nibble SHALL be shifted only if capture_pending = 0 and (word_valid_o = 0 or word_ready_i = 1); otherwise FSM enters STALL with sck_en_o = shift_valid_o = 0 and returns to SHIFT the cycle the condition holds.
REQ-022 word_o, word_bytes_o, word_last_o SHALL be stable while word_valid_o = 1 and word_ready_i = 0; word_valid_o clears on acceptance unless a new capture occurs the same cycle.
REQ-023 After the final nibble FSM enters DRAIN; on acceptance of the last word -> IDLE with done_o pulse that cycle+1.
REQ-024 busy_o = 1 in SHIFT, STALL, DRAIN.
REQ-025 abort_i SHALL win over all events: next cycle FSM IDLE, word_valid_o = 0, capture_pending = 0, counters 0, no done_o.

Reset
REQ-026 On rst_ni low, asynchronously: FSM IDLE; all counters 0; sck_en_o, shift_valid_o, shift_lsb_o, word_valid_o, word_last_o, busy_o, done_o = 0; shift_msb_o = 1; word_o = 0; word_bytes_o = 0.
REQ-027 Reset deasserted mid-transfer SHALL resume from IDLE only; no partial word is emitted.

Structure
REQ-028 State enum, nibble-per-word constant (8), and word width (32) SHALL live in shared package qspi_pkg.
REQ-029 Counter/ FSM logic SHALL be one module; the word holding register MAY be sub-module qspi_rx_word_reg; the RX shift stage is instantiated by the parent, not inside this block.

Verification
REQ-030 len 4, ready tied 1, msb mode -> 8 sck_en_o cycles contiguous, one word, word_bytes_o = 4, word_last_o = 1, done_o one cycle after acceptance.
REQ-031 len 10, ready tied 1 -> 20 contiguous sck_en_o cycles, words with bytes 4,4,2, last flag only on third.
REQ-032 len 8, word_ready_i held 0 for 12 cycles after first word -> sck_en_o drops before 16th nibble, second word not captured until first accepted, no data loss.
REQ-033 lsb_first_i = 1, len 1 -> shift_lsb_o = 1, shift_msb_o = 0, 2 nibbles, word_bytes_o = 1.
REQ-034 abort_i at nibble 5 of len 8 -> IDLE next cycle, no word_valid_o, no done_o; start_i while busy ignored.
REQ-035 rst_ni asserted mid-STALL with word_valid_o = 1 -> all outputs at REQ-026 values immediately, no clock needed.
